// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment display path: samples the segment bus
// and digit strobe, accepts stable patterns, and assembles frames of BCD digits.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     err_out,
    output logic                      digit_valid,
    output logic                      frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Exact-match decode; bit 4 of the result is the error flag.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1111110: res = {1'b0, 4'h0};
            7'b0110000: res = {1'b0, 4'h1};
            7'b1101101: res = {1'b0, 4'h2};
            7'b1111001: res = {1'b0, 4'h3};
            7'b0110001: res = {1'b0, 4'h4};
            7'b1011011: res = {1'b0, 4'h5};
            7'b1011111: res = {1'b0, 4'h6};
            7'b1110000: res = {1'b0, 4'h7};
            7'b1111111: res = {1'b0, 4'h8};
            7'b1111011: res = {1'b0, 4'h9};
            default:    res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    function automatic logic [IW-1:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
        logic [IW-1:0] idx;
        idx = IW'(0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [6:0]              s_seg_r, p_seg_r;
    logic [NUM_DIGITS-1:0]   s_sel_r, p_sel_r;
    logic [CW-1:0]           cnt_r;
    logic                    captured_r;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_r;
    logic [NUM_DIGITS-1:0]   shadow_err_r;
    logic [NUM_DIGITS-1:0]   seen_r;

    logic                    force_zero_s;
    logic [CW-1:0]           cnt_next_s;
    logic                    capture_s;
    logic [IW-1:0]           idx_s;
    logic [4:0]              dec_s;
    logic                    frame_done_s;
    logic [NUM_DIGITS-1:0]   seen_next_s;

    // Stability tracking, capture decision and seen-mask update.
    always_comb begin
        force_zero_s = !is_onehot(s_sel_r) || (s_sel_r != p_sel_r) || (s_seg_r != p_seg_r);
        cnt_next_s   = CW'(0);
        if (force_zero_s) begin
            cnt_next_s = CW'(0);
        end else if (cnt_r == CNT_MAX) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
        capture_s    = !force_zero_s && (cnt_next_s == CNT_MAX) && !captured_r;
        idx_s        = onehot_index(s_sel_r);
        dec_s        = seg_decode(s_seg_r);
        frame_done_s = &seen_r;
        seen_next_s  = frame_done_s ? '0 : seen_r;
        if (capture_s) begin
            seen_next_s[idx_s] = 1'b1;
        end else begin
            seen_next_s = seen_next_s;
        end
    end

    // Sample pipeline, counter, shadow store and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg_r      <= 7'd0;
            p_seg_r      <= 7'd0;
            s_sel_r      <= '0;
            p_sel_r      <= '0;
            cnt_r        <= CW'(0);
            captured_r   <= 1'b0;
            shadow_bcd_r <= '0;
            shadow_err_r <= '0;
            seen_r       <= '0;
            bcd_out      <= '0;
            err_out      <= '0;
            digit_valid  <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            s_seg_r     <= seg_in;
            s_sel_r     <= dig_sel;
            p_seg_r     <= s_seg_r;
            p_sel_r     <= s_sel_r;
            cnt_r       <= cnt_next_s;
            captured_r  <= force_zero_s ? 1'b0 : (captured_r | capture_s);
            seen_r      <= seen_next_s;
            digit_valid <= capture_s;
            frame_valid <= frame_done_s;
            if (capture_s) begin
                shadow_bcd_r[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
                shadow_err_r[idx_s]               <= dec_s[4];
            end else begin
                shadow_bcd_r <= shadow_bcd_r;
                shadow_err_r <= shadow_err_r;
            end
            // Outputs take the shadow contents as they stood before any same-cycle capture.
            if (frame_done_s) begin
                bcd_out <= shadow_bcd_r;
                err_out <= shadow_err_r;
            end else begin
                bcd_out <= bcd_out;
                err_out <= err_out;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of full frames plus hand-written
// sequences for reset, glitch, strobe-fault and mid-frame reset cases.
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110001, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        digit_valid;
    logic        frame_valid;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .err_out(err_out),
        .digit_valid(digit_valid), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int apply_cyc = 0;
    logic [15:0] last_bcd = 16'h0;
    logic [3:0]  last_err = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (digit_valid) dv_cnt <= dv_cnt + 1;
        if (frame_valid) begin
            fv_cnt   <= fv_cnt + 1;
            fv_cyc   <= cyc;
            last_bcd <= bcd_out;
            last_err <= err_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel   = sel;
        seg_in    = seg;
        apply_cyc = cyc;
        repeat (n) step();
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        show(4'b0001, s0, 8);
        show(4'b0010, s1, 8);
        show(4'b0100, s2, 8);
        show(4'b1000, s3, 8);
    endtask

    typedef struct {
        logic [6:0]  s0, s1, s2, s3;
        logic [15:0] bcd;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int dv0, fv0;
        vecs[0] = '{s0: P1, s1: P2, s2: P3, s3: P4, bcd: 16'h4321, err: 4'b0000};
        vecs[1] = '{s0: P9, s1: 7'b0000001, s2: P9, s3: P9, bcd: 16'h99F9, err: 4'b0010};
        vecs[2] = '{s0: P9, s1: P7, s2: P9, s3: P9, bcd: 16'h9979, err: 4'b0000};
        vecs[3] = '{s0: P0, s1: P5, s2: P6, s3: P8, bcd: 16'h8650, err: 4'b0000};
        vecs[4] = '{s0: P8, s1: P1, s2: P0, s3: 7'b0000000, bcd: 16'hF018, err: 4'b1000};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seg_in  = 7'($urandom);
            dig_sel = 4'($urandom);
            step();
            chk("rst_bcd", 32'(bcd_out), 32'h0);
            chk("rst_err", 32'(err_out), 32'h0);
            chk("rst_dv", 32'(digit_valid), 32'h0);
            chk("rst_fv", 32'(frame_valid), 32'h0);
        end
        rst_n = 1'b1;
        show(4'b0000, 7'd0, 10);
        chk("post_rst_dv", 32'(dv_cnt), 32'd0);
        chk("post_rst_fv", 32'(fv_cnt), 32'd0);

        // Table-driven full frames
        for (int v = 0; v < 5; v++) begin
            dv0 = dv_cnt;
            fv0 = fv_cnt;
            scan4(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
            chk($sformatf("frame%0d_dv", v), 32'(dv_cnt - dv0), 32'd4);
            chk($sformatf("frame%0d_fv", v), 32'(fv_cnt - fv0), 32'd1);
            chk($sformatf("frame%0d_bcd", v), 32'(last_bcd), 32'(vecs[v].bcd));
            chk($sformatf("frame%0d_err", v), 32'(last_err), 32'(vecs[v].err));
            chk($sformatf("frame%0d_hold", v), 32'(bcd_out), 32'(vecs[v].bcd));
            chk($sformatf("frame%0d_lat", v), 32'(fv_cyc - apply_cyc), 32'd6);
        end

        // Glitch rejection on digit 2
        dv0 = dv_cnt;
        fv0 = fv_cnt;
        show(4'b0001, P1, 8);
        show(4'b0010, P1, 8);
        show(4'b1000, P1, 8);
        show(4'b0100, P0, 3);
        show(4'b0100, P5, 8);
        chk("glitch_dv", 32'(dv_cnt - dv0), 32'd4);
        chk("glitch_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("glitch_bcd", 32'(last_bcd), 32'h1511);

        // Strobe faults mid-frame
        dv0 = dv_cnt;
        fv0 = fv_cnt;
        show(4'b0001, P3, 8);
        show(4'b0010, P8, 8);
        chk("pre_fault_dv", 32'(dv_cnt - dv0), 32'd2);
        dv0 = dv_cnt;
        show(4'b0000, P5, 10);
        show(4'b0011, P5, 10);
        chk("fault_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("fault_fv", 32'(fv_cnt - fv0), 32'd0);
        show(4'b0100, P9, 8);
        show(4'b1000, P0, 8);
        chk("fault_fv_after", 32'(fv_cnt - fv0), 32'd1);
        chk("fault_bcd", 32'(last_bcd), 32'h0983);
        chk("fault_err", 32'(last_err), 32'h0);

        // Mid-frame reset discards captured digits 0 and 1
        show(4'b0001, P6, 8);
        show(4'b0010, P7, 8);
        rst_n   = 1'b0;
        dig_sel = 4'b0000;
        seg_in  = 7'd0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
        chk("mid_rst_err", 32'(err_out), 32'h0);
        fv0 = fv_cnt;
        show(4'b0100, P1, 8);
        show(4'b1000, P2, 8);
        show(4'b0000, 7'd0, 4);
        chk("mid_rst_no_fv", 32'(fv_cnt - fv0), 32'd0);
        chk("mid_rst_bcd_hold", 32'(bcd_out), 32'h0);
        show(4'b0001, P6, 8);
        show(4'b0010, P7, 8);
        chk("mid_rst_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("mid_rst_frame", 32'(last_bcd), 32'h2176);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the team's 7-segment display path: samples a multiplexed display bus (segment pattern plus one-hot digit strobe) and recovers the BCD digits being shown.
- Used to loop back and self-check display drivers, and to read a display driven by another board.
- Requires each pattern to be stable before accepting it, assembles a full frame of digits, and flags patterns that are not in the team's encoding table.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (strobe width); legal 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted; legal 2..255.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- seg_in  input  7  segment pattern; bit6=a … bit0=g; active-high.
- dig_sel  input  NUM_DIGITS  digit strobe; active-high; bit i selects digit i.
- bcd_out  output  4*NUM_DIGITS  decoded frame; digit i in bits [4i+3:4i].
- err_out  output  NUM_DIGITS  bit i set: digit i in the current frame held an undecodable pattern.
- digit_valid  output  1  one-cycle pulse on each accepted digit.
- frame_valid  output  1  one-cycle pulse when bcd_out/err_out update.

Behaviour:
- Reset (rst_n low at a clock edge): bcd_out=0, err_out=0, digit_valid=0, frame_valid=0. Sample registers, stability counter, captured flag, shadow store and seen mask are all cleared. Reset takes priority over every other event, including in mid-frame. A partial frame is discarded.
- Stage 1: seg_in and dig_sel are registered into s_seg/s_sel every cycle. This gives 1 cycle of input latency.
- Stability counter (width ceil(log2(STABLE_CYCLES+1))):
  - cnt := 0 if s_sel is not one-hot (all-zero or multi-hot), or if (s_sel, s_seg) differs from the previous cycle's pair.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - A new pair starts at cnt=0 on its first sample cycle.
- Capture: on the edge where cnt==STABLE_CYCLES-1 is reached and the captured flag is 0:
  - Decode s_seg.
  - Write the result into shadow slot idx (idx = index of the set bit of s_sel). Set seen[idx]. Set captured=1.
  - Pulse digit_valid for the following cycle.
- The captured flag clears whenever cnt is forced to 0. This allows exactly one capture per stable strobe period.
- Recapturing a digit already in seen overwrites its slot. This is not an error.
- Decode table (exact match only):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110001→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
- Any other pattern, including 0000000, decodes to 4'hF with the slot's err bit set. Valid decodes clear the slot's err bit.
- Frame completion: on the edge after seen becomes all-ones:
  - Copy shadow digits/err bits to bcd_out/err_out.
  - Pulse frame_valid for 1 cycle.
  - Clear seen.
  - A capture arriving in that same cycle is kept in shadow and counts toward the next frame.
- bcd_out/err_out hold their values between frame_valid pulses.
- Minimum latency, from seg_in/dig_sel of the final digit applied to frame_valid high: 1 (register) + STABLE_CYCLES + 1 cycles = 6 at defaults.
- Glitches shorter than STABLE_CYCLES samples are never captured.
- Digit order is irrelevant; any scan order completes a frame.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs → all outputs 0, no digit_valid/frame_valid pulses; release → none until a stable capture.
- Full frame: scan digits 0..3 with patterns for 1,2,3,4 (4 = 0110001), 8 cycles each → four digit_valid pulses, then one frame_valid; bcd_out=16'h4321, err_out=4'b0000; first frame_valid exactly 6 cycles after digit 3 is applied.
- Glitch rejection: on digit 2, show 1111110 for 3 cycles, then 1011011 for 8 → one capture only, value 5; 0 never appears.
- Invalid pattern: digit 1 = 0000001 in a frame with 9,9,x,9 → bcd_out=16'h99F9, err_out=4'b0010; next frame with valid 7 on digit 1 → err_out=0.
- Strobe faults: dig_sel=0000 and dig_sel=0011 held for 10 cycles each → no digit_valid, seen unchanged; a subsequent clean scan completes normally.
- Mid-frame reset: capture digits 0,1, pulse rst_n low for 1 cycle, then scan 2,3 → no frame_valid until 0 and 1 are recaptured; bcd_out stays 0 until then.
